timed_setting_scheduler: RTL and testbench

- Timed command queue and settings-bus arbiter in front of the radio datapath core's settings port.
- Host settings writes either pass straight through or are captured as queued commands {time, addr, data}.
- Queued commands are replayed onto the datapath settings bus when vita_time reaches their timestamp, so gain, loopback and RX-control writes land on exact sample times.

---
 rtl/timed_setting_scheduler_if.sv | 15 +
 rtl/timed_setting_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_timed_setting_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timed_setting_scheduler_if.sv
// rtl/timed_setting_scheduler_if.sv - settings write channel interface
// Purpose: one settings write channel (strobe, address, data).
// Signals:
//   stb        one-cycle write strobe
//   addr[7:0]  settings register address
//   data[31:0] settings write data
// Modports: master drives the channel, slave receives it.
interface timed_setting_scheduler_if;
  logic        stb;
  logic [7:0]  addr;
  logic [31:0] data;

  modport master (output stb, output addr, output data);
  modport slave  (input stb, input addr, input data);
endinterface

// File: rtl/timed_setting_scheduler.sv
// rtl/timed_setting_scheduler.sv - timed command queue and settings-bus arbiter
// Purpose: host settings writes either pass straight to the datapath settings
//   bus (latency 1) or are captured as {time, addr, data} commands and replayed
//   in FIFO order once vita_time reaches each command's timestamp.
// Ports:
//   clk, reset      block clock, asynchronous active-high reset
//   vita_time[63:0] current VITA time, same clock domain
//   host            slave settings channel from the host
//   core            master settings channel to the datapath core
//   fill            queued entry count
//   late_count      late commands seen, saturating
//   overflow        sticky: push attempted while full
//   busy            queue non-empty or a command in flight
// Optional feature: define TIMED_SCHED_LATE_EXEC_EN to execute late commands
//   instead of dropping them (late_count still increments).
module timed_setting_scheduler #(
  parameter int         FIFO_AWIDTH    = 4,
  parameter logic [7:0] SR_CMD_TIME_HI = 8'd200,
  parameter logic [7:0] SR_CMD_TIME_LO = 8'd201,
  parameter logic [7:0] SR_CMD_ADDR    = 8'd202,
  parameter logic [7:0] SR_CMD_DATA    = 8'd203,
  parameter logic [7:0] SR_CMD_CLEAR   = 8'd204
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               vita_time,
  timed_setting_scheduler_if.slave  host,
  timed_setting_scheduler_if.master core,
  output logic [FIFO_AWIDTH:0]      fill,
  output logic [15:0]               late_count,
  output logic                      overflow,
  output logic                      busy
);

  localparam int DEPTH = 1 << FIFO_AWIDTH;
  localparam logic [FIFO_AWIDTH:0] FULL_COUNT = (FIFO_AWIDTH+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] ts;
    logic [7:0]  addr;
    logic        timed;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t                 state, state_n;
  logic [31:0]            stage_hi, stage_lo;
  logic [7:0]             stage_addr;
  logic                   stage_timed;
  cmd_t                   mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AWIDTH:0]   count;
  cmd_t                   head;
  logic                   first_wait;

  logic is_cmd_addr, pt_hit, push_req, clr_hit, full, push_ok;
  logic pop, late_hit, issue_fire;

  assign is_cmd_addr = (host.addr == SR_CMD_TIME_HI) || (host.addr == SR_CMD_TIME_LO) ||
                       (host.addr == SR_CMD_ADDR)    || (host.addr == SR_CMD_DATA)    ||
                       (host.addr == SR_CMD_CLEAR);
  assign pt_hit   = host.stb && !is_cmd_addr;
  assign push_req = host.stb && (host.addr == SR_CMD_DATA);
  assign clr_hit  = host.stb && (host.addr == SR_CMD_CLEAR);
  // Fullness is judged on the pre-pop count, so a same-cycle pop never admits a push.
  assign full     = (count == FULL_COUNT);
  assign push_ok  = push_req && !full;

  assign fill = count;
  assign busy = (count != '0) || (state != S_IDLE);

  // Staging registers survive pushes and clears; only reset zeroes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_hi    <= '0;
      stage_lo    <= '0;
      stage_addr  <= '0;
      stage_timed <= 1'b0;
    end else if (host.stb) begin
      if (host.addr == SR_CMD_TIME_HI) stage_hi <= host.data;
      if (host.addr == SR_CMD_TIME_LO) stage_lo <= host.data;
      if (host.addr == SR_CMD_ADDR) begin
        stage_addr  <= host.data[7:0];
        stage_timed <= host.data[31];
      end
    end
  end

  // Queue storage needs no reset: emptiness is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{ts: {stage_hi, stage_lo}, addr: stage_addr,
                                  timed: stage_timed, data: host.data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_hit) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scheduler next-state logic. Lateness is judged only on the first WAIT
  // cycle; later forward jumps of vita_time simply make the entry ready.
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    late_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (first_wait && head.timed && (head.ts < vita_time)) begin
          late_hit = 1'b1;
`ifdef TIMED_SCHED_LATE_EXEC_EN
          state_n  = S_ISSUE;
`else
          state_n  = S_IDLE;
`endif
        end else if (!head.timed || (vita_time >= head.ts)) begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A passthrough write owns the output this cycle; retry next cycle.
        if (!pt_hit) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (clr_hit) begin
      state_n  = S_IDLE;
      pop      = 1'b0;
      late_hit = 1'b0;
    end
  end

  assign issue_fire = (state == S_ISSUE) && !pt_hit && !clr_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      head       <= '0;
      first_wait <= 1'b0;
    end else begin
      state      <= state_n;
      first_wait <= pop;
      if (pop) head <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      late_count <= '0;
      overflow   <= 1'b0;
    end else if (clr_hit) begin
      late_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (late_hit && (late_count != 16'hFFFF)) late_count <= late_count + 1'b1;
      if (push_req && full) overflow <= 1'b1;
    end
  end

  // Single output register: at most one strobe per cycle, passthrough first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core.stb  <= 1'b0;
      core.addr <= '0;
      core.data <= '0;
    end else if (pt_hit) begin
      core.stb  <= 1'b1;
      core.addr <= host.addr;
      core.data <= host.data;
    end else if (issue_fire) begin
      core.stb  <= 1'b1;
      core.addr <= head.addr;
      core.data <= head.data;
    end else begin
      core.stb  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timed_setting_scheduler.sv
// tb/tb_timed_setting_scheduler.sv - self-checking bench for timed_setting_scheduler
module tb_timed_setting_scheduler;
  localparam logic [7:0] A_HI   = 8'd200;
  localparam logic [7:0] A_LO   = 8'd201;
  localparam logic [7:0] A_ADDR = 8'd202;
  localparam logic [7:0] A_DATA = 8'd203;
  localparam logic [7:0] A_CLR  = 8'd204;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
    logic [63:0] vt;
  } obs_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [63:0] ts;
    logic        timed;
  } cmd_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] vita_time;
  logic [4:0]  fill;
  logic [15:0] late_count;
  logic        overflow;
  logic        busy;
  logic [63:0] vt_step;
  int          tcycle = 0;
  int          checks;
  int          failures;

  obs_t        obs_q[$];
  cmd_exp_t    cmd_exp[$];
  logic [39:0] pt_exp[$];

  timed_setting_scheduler_if host_bus();
  timed_setting_scheduler_if core_bus();

  timed_setting_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .vita_time  (vita_time),
    .host       (host_bus),
    .core       (core_bus),
    .fill       (fill),
    .late_count (late_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tcycle <= tcycle + 1;

  always @(posedge clk) begin
    #1;
    if (core_bus.stb === 1'b1)
      obs_q.push_back('{addr: core_bus.addr, data: core_bus.data, cyc: tcycle, vt: vita_time});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    vita_time = vita_time + vt_step;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    host_bus.stb  = 1'b1;
    host_bus.addr = a;
    host_bus.data = d;
    tick();
    host_bus.stb  = 1'b0;
  endtask

  task automatic push_cmd(input logic [63:0] t, input logic timed, input logic [7:0] a,
                          input logic [31:0] d);
    wr(A_HI, t[63:32]);
    wr(A_LO, t[31:0]);
    wr(A_ADDR, {timed, 23'd0, a});
    wr(A_DATA, d);
  endtask

  initial begin
    int          t1100;
    int          ci;
    int          pi;
    int          npush;
    int          r;
    logic [7:0]  pa;
    logic [31:0] pd;
    logic [63:0] ts;
    logic        tm;
    logic [7:0]  ca;
    logic [31:0] cd;

    checks = 0; failures = 0; vt_step = 64'd0; vita_time = 64'd0;
    host_bus.stb = 1'b0; host_bus.addr = 8'd0; host_bus.data = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_stb",  64'(core_bus.stb),  64'd0);
    check("rst_addr", 64'(core_bus.addr), 64'd0);
    check("rst_data", 64'(core_bus.data), 64'd0);
    check("rst_fill", 64'(fill),          64'd0);
    check("rst_late", 64'(late_count),    64'd0);
    check("rst_ovf",  64'(overflow),      64'd0);
    check("rst_busy", 64'(busy),          64'd0);

    // Passthrough, latency 1
    wr(8'h10, 32'hA5A5);
    check("pt_stb",  64'(core_bus.stb),  64'd1);
    check("pt_addr", 64'(core_bus.addr), 64'h10);
    check("pt_data", 64'(core_bus.data), 64'hA5A5);
    check("pt_fill", 64'(fill),          64'd0);
    tick();
    check("pt_stb_off", 64'(core_bus.stb), 64'd0);

    // Immediate command, minimum latency (strobe three edges after push)
    push_cmd(64'd0, 1'b0, 8'h30, 32'hC0DE0001);
    check("lat_fill1", 64'(fill),         64'd1);
    check("lat_n0",    64'(core_bus.stb), 64'd0);
    tick();
    check("lat_busy",  64'(busy),         64'd1);
    check("lat_n1",    64'(core_bus.stb), 64'd0);
    tick();
    check("lat_n2",    64'(core_bus.stb), 64'd0);
    tick();
    check("lat_stb",   64'(core_bus.stb),  64'd1);
    check("lat_addr",  64'(core_bus.addr), 64'h30);
    check("lat_data",  64'(core_bus.data), 64'hC0DE0001);
    tick();
    check("lat_stb_off", 64'(core_bus.stb), 64'd0);
    check("lat_idle",    64'(busy),         64'd0);

    // Timed issue at 1100
    vita_time = 64'd1000;
    obs_q.delete();
    push_cmd(64'd1100, 1'b1, 8'h12, 32'd7);
    vt_step = 64'd1;
    t1100 = -1000;
    repeat (120) begin
      tick();
      if (vita_time == 64'd1100) t1100 = tcycle;
    end
    vt_step = 64'd0;
    check("timed_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) begin
      check("timed_addr",   64'(obs_q[0].addr), 64'h12);
      check("timed_data",   64'(obs_q[0].data), 64'd7);
      check("timed_notearly", 64'(obs_q[0].vt >= 64'd1100), 64'd1);
      check("timed_window", 64'((obs_q[0].cyc - t1100 >= 1) && (obs_q[0].cyc - t1100 <= 3)), 64'd1);
    end

    // Late command
    vita_time = 64'd5000;
    obs_q.delete();
    push_cmd(64'd4000, 1'b1, 8'h14, 32'h99);
    repeat (8) tick();
    check("late_count", 64'(late_count), 64'd1);
`ifdef TIMED_SCHED_LATE_EXEC_EN
    check("late_strobes", 64'(obs_q.size()), 64'd1);
`else
    check("late_strobes", 64'(obs_q.size()), 64'd0);
`endif
    check("late_busy", 64'(busy), 64'd0);

    // Overflow and clear (first entry sits in WAIT, 16 more fill the queue)
    obs_q.delete();
    wr(A_HI, 32'd256);
    wr(A_LO, 32'd0);
    wr(A_ADDR, 32'h8000_0040);
    for (int i = 0; i < 17; i++) wr(A_DATA, 32'(i));
    check("ovf_fill16", 64'(fill), 64'd16);
    check("ovf_busy",   64'(busy), 64'd1);
    wr(A_DATA, 32'd99);
    check("ovf_fill_hold", 64'(fill),     64'd16);
    check("ovf_flag",      64'(overflow), 64'd1);
    wr(A_CLR, 32'd0);
    check("clr_fill", 64'(fill),       64'd0);
    check("clr_ovf",  64'(overflow),   64'd0);
    check("clr_busy", 64'(busy),       64'd0);
    check("clr_late", 64'(late_count), 64'd0);
    repeat (5) tick();
    check("clr_nostb", 64'(obs_q.size()), 64'd0);

    // Collision: passthrough lands on the issue cycle
    push_cmd(64'd0, 1'b0, 8'h31, 32'h1111_2222);
    tick();
    tick();
    wr(8'h20, 32'h3333_4444);
    check("col_pt_stb",  64'(core_bus.stb),  64'd1);
    check("col_pt_addr", 64'(core_bus.addr), 64'h20);
    check("col_pt_data", 64'(core_bus.data), 64'h3333_4444);
    tick();
    check("col_q_stb",  64'(core_bus.stb),  64'd1);
    check("col_q_addr", 64'(core_bus.addr), 64'h31);
    check("col_q_data", 64'(core_bus.data), 64'h1111_2222);
    tick();
    check("col_off", 64'(core_bus.stb), 64'd0);

    // Reset while a timed entry waits
    vita_time = 64'd100;
    push_cmd(64'd200, 1'b1, 8'h15, 32'h55);
    repeat (3) tick();
    check("rw_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rw_busy", 64'(busy),         64'd0);
    check("rw_fill", 64'(fill),         64'd0);
    check("rw_stb",  64'(core_bus.stb), 64'd0);
    tick();
    reset = 1'b0;
    obs_q.delete();
    vt_step = 64'd1;
    repeat (150) tick();
    vt_step = 64'd0;
    check("rw_nostb", 64'(obs_q.size()), 64'd0);

    // Randomized mix against a transaction-level model
    vita_time = 64'd10000;
    obs_q.delete();
    pt_exp.delete();
    cmd_exp.delete();
    npush = 0;
    wr(A_HI, 32'd0);
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 2));
      if (r == 0 || npush >= 14) begin
        pa = 8'($urandom_range(0, 63));
        pd = $urandom;
        wr(pa, pd);
        pt_exp.push_back({pa, pd});
      end else begin
        ts = 64'd10020 + 64'(12 * npush);
        tm = 1'($urandom_range(0, 1));
        ca = 8'h80 | 8'($urandom_range(0, 63));
        cd = $urandom;
        wr(A_LO, ts[31:0]);
        wr(A_ADDR, {tm, 23'd0, ca});
        wr(A_DATA, cd);
        cmd_exp.push_back('{addr: ca, data: cd, ts: ts, timed: tm});
        npush++;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    vt_step = 64'd1;
    repeat (260) tick();
    vt_step = 64'd0;

    ci = 0;
    pi = 0;
    foreach (obs_q[k]) begin
      if (obs_q[k].addr[7]) begin
        if (ci < cmd_exp.size()) begin
          check("rnd_cmd_addr", 64'(obs_q[k].addr), 64'(cmd_exp[ci].addr));
          check("rnd_cmd_data", 64'(obs_q[k].data), 64'(cmd_exp[ci].data));
          if (cmd_exp[ci].timed)
            check("rnd_cmd_time", 64'(obs_q[k].vt >= cmd_exp[ci].ts), 64'd1);
        end
        ci++;
      end else begin
        if (pi < pt_exp.size())
          check("rnd_pt", 64'({obs_q[k].addr, obs_q[k].data}), 64'(pt_exp[pi]));
        pi++;
      end
    end
    check("rnd_cmd_count", 64'(ci), 64'(cmd_exp.size()));
    check("rnd_pt_count",  64'(pi), 64'(pt_exp.size()));
    check("rnd_late",      64'(late_count), 64'd0);
    check("rnd_fill",      64'(fill),       64'd0);
    check("rnd_busy",      64'(busy),       64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
